// File: rtl/sequence_checker.sv
`default_nettype none
// ============================================================================
// Module      : sequence_checker
// Description : Receive-side checker for the candidate-sequence stream.
//               Verifies the zero prefix, the fixed field and a contiguous
//               counter field. Counts accepted candidates, flags matches
//               against a target, and reports clean completion or the
//               first error detected.
//               Optional feature: define SEQ_CHECKER_TIMEOUT_EN to enable
//               the idle-beat timeout (error code 5) while running.
// Revision    : 1.0 - initial release
// ============================================================================
module sequence_checker #(
    parameter int SEQ_WIDTH = 8,
    parameter int FIX_WIDTH = 2,
    parameter int FIX_SEQ   = 0,
    parameter int TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SEQ_WIDTH-1:0]   i_seq,
    input  logic                   i_valid,
    input  logic                   i_done,
    input  logic [SEQ_WIDTH-1:0]   i_target,
    output logic                   o_match,
    output logic [SEQ_WIDTH-1:0]   o_match_seq,
    output logic [SEQ_WIDTH-FIX_WIDTH-2:0] o_count,
    output logic                   o_finished,
    output logic                   o_error,
    output logic [2:0]             o_err_code
);

    localparam int CNT_W = SEQ_WIDTH - FIX_WIDTH - 2;
    localparam logic [CNT_W-1:0]     LIMIT   = {CNT_W{1'b1}};
    localparam logic [FIX_WIDTH-1:0] FIX_VAL = FIX_WIDTH'(FIX_SEQ);

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_PREMATURE = 3'd1;
    localparam logic [2:0] ERR_PREFIX   = 3'd2;
    localparam logic [2:0] ERR_FIX      = 3'd3;
    localparam logic [2:0] ERR_GAP      = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Field views of the incoming candidate
    logic [1:0]           seq_prefix;
    logic [FIX_WIDTH-1:0] seq_fix;
    logic [CNT_W-1:0]     seq_cnt;

    assign seq_prefix = i_seq[SEQ_WIDTH-1 -: 2];
    assign seq_fix    = i_seq[CNT_W +: FIX_WIDTH];
    assign seq_cnt    = i_seq[CNT_W-1:0];

    // Current state
    state_t               state;
    logic [CNT_W-1:0]     exp_cnt;
    logic                 all_seen;
    logic [CNT_W:0]       acc_count;
    logic                 match_pulse;
    logic [SEQ_WIDTH-1:0] match_value;
    logic                 finished;
    logic                 error_flag;
    logic [2:0]           err_code;

    // Next state
    state_t               state_next;
    logic [CNT_W-1:0]     exp_cnt_next;
    logic                 all_seen_next;
    logic [CNT_W:0]       acc_count_next;
    logic                 match_pulse_next;
    logic [SEQ_WIDTH-1:0] match_value_next;
    logic                 finished_next;
    logic                 error_flag_next;
    logic [2:0]           err_code_next;

    // Per-beat classification
    logic                 accept;
    logic [2:0]           beat_code;
    logic                 timeout_hit;

`ifdef SEQ_CHECKER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [TO_W-1:0] idle_cnt;

    // The stall that would bring the idle counter to TIMEOUT is the error cycle
    assign timeout_hit = (state == RUN) && !i_valid &&
                         ((idle_cnt + TO_W'(1)) == TO_W'(TIMEOUT));

    // Idle counter: counts beat-less cycles in RUN, zero everywhere else
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state == RUN && !i_valid) begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    // Without the timeout feature the hit condition is constant false
    localparam logic TIMEOUT_ON = (TIMEOUT < 0);
    assign timeout_hit = TIMEOUT_ON;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            exp_cnt     <= '0;
            all_seen    <= 1'b0;
            acc_count   <= '0;
            match_pulse <= 1'b0;
            match_value <= '0;
            finished    <= 1'b0;
            error_flag  <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            state       <= state_next;
            exp_cnt     <= exp_cnt_next;
            all_seen    <= all_seen_next;
            acc_count   <= acc_count_next;
            match_pulse <= match_pulse_next;
            match_value <= match_value_next;
            finished    <= finished_next;
            error_flag  <= error_flag_next;
            err_code    <= err_code_next;
        end
    end

    // Beat evaluation first, then done / timeout rules on the post-beat view
    always_comb begin
        state_next       = state;
        exp_cnt_next     = exp_cnt;
        all_seen_next    = all_seen;
        acc_count_next   = acc_count;
        match_pulse_next = 1'b0;
        match_value_next = match_value;
        finished_next    = finished;
        error_flag_next  = error_flag;
        err_code_next    = err_code;
        accept           = 1'b0;
        beat_code        = ERR_NONE;

        if (state == IDLE || state == RUN) begin
            if (i_valid) begin
                if (state == IDLE) begin
                    state_next = RUN;
                end
                if (seq_prefix != 2'b00) begin
                    beat_code = ERR_PREFIX;
                end else if (seq_fix != FIX_VAL) begin
                    beat_code = ERR_FIX;
                end else if (!all_seen && seq_cnt == exp_cnt) begin
                    accept = 1'b1;
                end else if (!(all_seen && seq_cnt == LIMIT)) begin
                    // Anything that is neither the expected value nor a
                    // repeated tail beat breaks the contiguous order
                    beat_code = ERR_GAP;
                end
            end

            if (accept) begin
                acc_count_next = acc_count + (CNT_W+1)'(1);
                if (exp_cnt == LIMIT) begin
                    all_seen_next = 1'b1;
                end else begin
                    exp_cnt_next = exp_cnt + CNT_W'(1);
                end
                if (i_seq == i_target) begin
                    match_pulse_next = 1'b1;
                    match_value_next = i_seq;
                end
            end

            if (beat_code != ERR_NONE) begin
                state_next      = ERR;
                error_flag_next = 1'b1;
                err_code_next   = beat_code;
            end else if (i_done) begin
                if (all_seen_next) begin
                    state_next    = DONE;
                    finished_next = 1'b1;
                end else begin
                    state_next      = ERR;
                    error_flag_next = 1'b1;
                    err_code_next   = ERR_PREMATURE;
                end
            end else if (timeout_hit) begin
                state_next      = ERR;
                error_flag_next = 1'b1;
                err_code_next   = ERR_TIMEOUT;
            end
        end
    end

    assign o_match     = match_pulse;
    assign o_match_seq = match_value;
    assign o_count     = acc_count;
    assign o_finished  = finished;
    assign o_error     = error_flag;
    assign o_err_code  = err_code;

endmodule
`default_nettype wire

// File: tb/tb_sequence_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sequence_checker
// Description : Directed self-checking bench for sequence_checker. A second
//               instance with FIX_SEQ=1 shares the stimulus for field tests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sequence_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_seq = 8'h00;
    logic       i_valid = 1'b0;
    logic       i_done = 1'b0;
    logic [7:0] i_target = 8'hFF;

    logic       o_match;
    logic [7:0] o_match_seq;
    logic [4:0] o_count;
    logic       o_finished;
    logic       o_error;
    logic [2:0] o_err_code;

    logic       f_match;
    logic [7:0] f_match_seq;
    logic [4:0] f_count;
    logic       f_finished;
    logic       f_error;
    logic [2:0] f_err_code;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sequence_checker dut (
        .clk         (clk),
        .rst         (rst),
        .i_seq       (i_seq),
        .i_valid     (i_valid),
        .i_done      (i_done),
        .i_target    (i_target),
        .o_match     (o_match),
        .o_match_seq (o_match_seq),
        .o_count     (o_count),
        .o_finished  (o_finished),
        .o_error     (o_error),
        .o_err_code  (o_err_code)
    );

    sequence_checker #(.FIX_SEQ(1)) dut_f (
        .clk         (clk),
        .rst         (rst),
        .i_seq       (i_seq),
        .i_valid     (i_valid),
        .i_done      (i_done),
        .i_target    (i_target),
        .o_match     (f_match),
        .o_match_seq (f_match_seq),
        .o_count     (f_count),
        .o_finished  (f_finished),
        .o_error     (f_error),
        .o_err_code  (f_err_code)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i_valid = 1'b0; i_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One beat; on return the registered response is visible
    task automatic beat(input logic [7:0] s, input logic d);
        @(negedge clk);
        i_seq = s; i_valid = 1'b1; i_done = d;
        @(negedge clk);
        i_valid = 1'b0; i_done = 1'b0;
    endtask

    task automatic done_only();
        @(negedge clk);
        i_done = 1'b1;
        @(negedge clk);
        i_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({o_match, o_match_seq, o_count, o_finished, o_error, o_err_code} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {o_match, o_match_seq, o_count, o_finished, o_error, o_err_code});
        end
    endtask

    task automatic test_clean_run();
        do_reset();
        i_target = 8'hFF;
        for (int i = 0; i < 16; i++) beat(8'(i), 1'b0);
        checks++;
        if (o_count !== 5'd16) begin
            errors++; $display("FAIL clean_count16: got %0d required 16", o_count);
        end
        checks++;
        if (o_finished !== 1'b0) begin
            errors++; $display("FAIL clean_not_yet_finished: got %b required 0", o_finished);
        end
        beat(8'h0F, 1'b0);
        checks++;
        if (o_error !== 1'b0 || o_count !== 5'd16) begin
            errors++; $display("FAIL clean_dup_ignored: got err=%b cnt=%0d required err=0 cnt=16", o_error, o_count);
        end
        beat(8'h0F, 1'b1);
        checks++;
        if (o_finished !== 1'b1 || o_error !== 1'b0 || o_count !== 5'd16 || o_err_code !== 3'd0) begin
            errors++; $display("FAIL clean_finish: got fin=%b err=%b cnt=%0d code=%0d required fin=1 err=0 cnt=16 code=0",
                               o_finished, o_error, o_count, o_err_code);
        end
        beat(8'h05, 1'b0);
        checks++;
        if (o_finished !== 1'b1 || o_error !== 1'b0) begin
            errors++; $display("FAIL clean_sticky: got fin=%b err=%b required fin=1 err=0", o_finished, o_error);
        end
    endtask

    task automatic test_gap();
        do_reset();
        beat(8'h00, 1'b0);
        beat(8'h01, 1'b0);
        beat(8'h03, 1'b0);
        checks++;
        if (o_error !== 1'b1 || o_err_code !== 3'd4 || o_count !== 5'd2) begin
            errors++; $display("FAIL gap_error: got err=%b code=%0d cnt=%0d required err=1 code=4 cnt=2",
                               o_error, o_err_code, o_count);
        end
        beat(8'h02, 1'b0);
        done_only();
        checks++;
        if (o_count !== 5'd2 || o_err_code !== 3'd4 || o_finished !== 1'b0) begin
            errors++; $display("FAIL gap_sticky: got cnt=%0d code=%0d fin=%b required cnt=2 code=4 fin=0",
                               o_count, o_err_code, o_finished);
        end
    endtask

    task automatic test_match();
        int pulses;
        do_reset();
        i_target = 8'h07;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            beat(8'(i), 1'b0);
            if (o_match === 1'b1) pulses++;
            if (i == 7) begin
                checks++;
                if (o_match !== 1'b1 || o_match_seq !== 8'h07) begin
                    errors++; $display("FAIL match_at_7: got m=%b seq=%h required m=1 seq=07", o_match, o_match_seq);
                end
            end
        end
        checks++;
        if (pulses != 1 || o_match_seq !== 8'h07) begin
            errors++; $display("FAIL match_single_7: got pulses=%0d seq=%h required 1 and 07", pulses, o_match_seq);
        end

        do_reset();
        i_target = 8'h0F;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            beat(8'(i), 1'b0);
            if (o_match === 1'b1) pulses++;
        end
        beat(8'h0F, 1'b0);
        if (o_match === 1'b1) pulses++;
        beat(8'h0F, 1'b0);
        if (o_match === 1'b1) pulses++;
        checks++;
        if (pulses != 1 || o_match_seq !== 8'h0F) begin
            errors++; $display("FAIL match_tail_once: got pulses=%0d seq=%h required 1 and 0f", pulses, o_match_seq);
        end
        i_target = 8'hFF;
    endtask

    task automatic test_premature_done();
        do_reset();
        for (int i = 0; i < 6; i++) beat(8'(i), 1'b0);
        done_only();
        checks++;
        if (o_error !== 1'b1 || o_err_code !== 3'd1 || o_finished !== 1'b0 || o_count !== 5'd6) begin
            errors++; $display("FAIL premature_done: got err=%b code=%0d fin=%b cnt=%0d required err=1 code=1 fin=0 cnt=6",
                               o_error, o_err_code, o_finished, o_count);
        end
    endtask

    task automatic test_back_to_back();
        // Erroring beat together with done: the beat's code wins
        do_reset();
        beat(8'h00, 1'b0);
        beat(8'h01, 1'b0);
        beat(8'h05, 1'b1);
        checks++;
        if (o_err_code !== 3'd4 || o_count !== 5'd2) begin
            errors++; $display("FAIL beat_vs_done: got code=%0d cnt=%0d required code=4 cnt=2", o_err_code, o_count);
        end
    endtask

    task automatic test_field_errors();
        do_reset();
        beat(8'h00, 1'b0);
        checks++;
        if (f_error !== 1'b1 || f_err_code !== 3'd3 || f_count !== 5'd0) begin
            errors++; $display("FAIL fix_mismatch: got err=%b code=%0d cnt=%0d required err=1 code=3 cnt=0",
                               f_error, f_err_code, f_count);
        end
        do_reset();
        beat(8'h90, 1'b0);
        checks++;
        if (f_err_code !== 3'd2 || o_err_code !== 3'd2) begin
            errors++; $display("FAIL prefix_priority: got f=%0d d=%0d required 2 and 2", f_err_code, o_err_code);
        end
        do_reset();
        beat(8'h10, 1'b0);
        checks++;
        if (f_error !== 1'b0 || f_count !== 5'd1 || o_err_code !== 3'd3) begin
            errors++; $display("FAIL fix_accept: got ferr=%b fcnt=%0d dcode=%0d required ferr=0 fcnt=1 dcode=3",
                               f_error, f_count, o_err_code);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) beat(8'(i), 1'b0);
        checks++;
        if (o_count !== 5'd8) begin
            errors++; $display("FAIL mid_count8: got %0d required 8", o_count);
        end
        do_reset();
        checks++;
        if (o_count !== 5'd0 || o_error !== 1'b0) begin
            errors++; $display("FAIL mid_reset_clear: got cnt=%0d err=%b required 0 0", o_count, o_error);
        end
        beat(8'h00, 1'b0);
        beat(8'h01, 1'b0);
        checks++;
        if (o_count !== 5'd2 || o_error !== 1'b0) begin
            errors++; $display("FAIL mid_restart: got cnt=%0d err=%b required cnt=2 err=0", o_count, o_error);
        end
    endtask

    task automatic test_timeout();
        logic       exp_err;
        logic [2:0] exp_code;
`ifdef SEQ_CHECKER_TIMEOUT_EN
        exp_err = 1'b1; exp_code = 3'd5;
`else
        exp_err = 1'b0; exp_code = 3'd0;
`endif
        // Idle in IDLE never times out
        do_reset();
        repeat (20) @(negedge clk);
        checks++;
        if (o_error !== 1'b0) begin
            errors++; $display("FAIL idle_no_timeout: got %b required 0", o_error);
        end
        beat(8'h00, 1'b0);
        repeat (15) @(negedge clk);
        checks++;
        if (o_error !== 1'b0) begin
            errors++; $display("FAIL stall15: got %b required 0", o_error);
        end
        @(negedge clk);
        checks++;
        if (o_error !== exp_err || o_err_code !== exp_code) begin
            errors++; $display("FAIL stall16: got err=%b code=%0d required err=%b code=%0d",
                               o_error, o_err_code, exp_err, exp_code);
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_gap();
        test_match();
        test_premature_done();
        test_back_to_back();
        test_field_errors();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
